pad_poll: RTL and testbench

Drives the two physical NES controller ports and turns their serial shift-register output into the parallel `input0`/`input1` button bytes. The io block consumes these bytes and re-serialises them to the CPU. On each `start` pulse, the block latches both pads and clocks out 8 bits from each pad simultaneously. It then commits the two bytes and pulses `valid`.

---
 rtl/pad_poll.sv | 157 +++++++++++++++
 tb/tb_pad_poll.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_poll.sv
// NES controller poller: latches both pads, clocks out 8 bits from each in lockstep
// and commits button bytes (bit 7 = A ... bit 0 = Right). Build option: PAD_DEBOUNCE_EN.
//   state | meaning
//   IDLE  | waiting for start, pad_clk high
//   LATCH | pad_latch high for 2*HALF cycles, sample bit 0 at the end
//   CLKLO | pad_clk low for HALF cycles
//   CLKHI | pad_clk high for HALF cycles, sample next bit at the end
//   DONE  | commit shift registers, pulse valid
module pad_poll #(
  parameter int HALF = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       valid,
  output logic [7:0] input0,
  output logic [7:0] input1,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data0,
  input  logic       pad_data1
);

  localparam int PW = $clog2(2*HALF+1);
  localparam logic [PW-1:0] LAT_LAST  = PW'(2*HALF-1);
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF-1);

  typedef enum logic [2:0] {IDLE, LATCH, CLKLO, CLKHI, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh0_q, sh0_d, sh1_q, sh1_d;
  logic [7:0]    in0_q, in0_d, in1_q, in1_d;
  logic          busy_q, busy_d, valid_q, valid_d;
  logic          latch_q, latch_d, pclk_q, pclk_d;
`ifdef PAD_DEBOUNCE_EN
  logic [7:0]    prev0_q, prev0_d, prev1_q, prev1_d;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    valid_d = 1'b0;
`ifdef PAD_DEBOUNCE_EN
    prev0_d = prev0_q;
    prev1_d = prev1_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
          phase_d = LAT_LAST;
        end
      end
      LATCH: begin
        if (phase_q == '0) begin
          sh0_d   = {sh0_q[6:0], ~pad_data0};
          sh1_d   = {sh1_q[6:0], ~pad_data1};
          bit_d   = 3'd1;
          state_d = CLKLO;
          phase_d = HALF_LAST;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      CLKLO: begin
        if (phase_q == '0) begin
          state_d = CLKHI;
          phase_d = HALF_LAST;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      CLKHI: begin
        if (phase_q == '0) begin
          sh0_d   = {sh0_q[6:0], ~pad_data0};
          sh1_d   = {sh1_q[6:0], ~pad_data1};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? DONE : CLKLO;
          phase_d = HALF_LAST;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      DONE: begin
`ifdef PAD_DEBOUNCE_EN
        // only a byte seen on two consecutive polls is committed
        if (sh0_q == prev0_q) in0_d = sh0_q;
        if (sh1_q == prev1_q) in1_d = sh1_q;
        prev0_d = sh0_q;
        prev1_d = sh1_q;
`else
        in0_d = sh0_q;
        in1_d = sh1_q;
`endif
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    latch_d = (state_d == LATCH);
    pclk_d  = (state_d != CLKLO);
    busy_d  = (state_d != IDLE) | valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
`ifdef PAD_DEBOUNCE_EN
      prev0_q <= '0;
      prev1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
`ifdef PAD_DEBOUNCE_EN
      prev0_q <= prev0_d;
      prev1_q <= prev1_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign input0    = in0_q;
  assign input1    = in1_q;
  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;

endmodule

// File: tb/tb_pad_poll.sv
// Bench for pad_poll: two instances (HALF=2 and HALF=1), each with a pad model,
// a scoreboard queue of expected button bytes and valid times, and a monitor.
module tb_pad_poll;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int H = (g == 0) ? 2 : 1;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, valid, pad_latch, pad_clk, pad_data0, pad_data1;
    logic [7:0] input0, input1;
    logic [7:0] btn0 = 8'h00, btn1 = 8'h00;
    logic       done_g = 1'b0;

    // reference state: committed bytes and the previous raw bytes
    logic [7:0] m_in0 = 8'h00, m_in1 = 8'h00, m_prev0 = 8'h00, m_prev1 = 8'h00;
    logic [15:0] exp_q[$];
    int          cyc_q[$];

    pad_poll #(.HALF(H)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .valid     (valid),
      .input0    (input0),
      .input1    (input1),
      .pad_latch (pad_latch),
      .pad_clk   (pad_clk),
      .pad_data0 (pad_data0),
      .pad_data1 (pad_data1)
    );

    // pad model: latch loads, each rising pad_clk advances to the next button
    int         idx = 0;
    logic [2:0] bitsel;
    always @(posedge pad_latch or posedge pad_clk) begin
      if (pad_latch) idx = 0;
      else if (idx < 8) idx = idx + 1;
    end
    assign bitsel    = 3'(7 - idx);
    assign pad_data0 = (idx < 8) ? ~btn0[bitsel] : 1'b0;
    assign pad_data1 = (idx < 8) ? ~btn1[bitsel] : 1'b0;

    int          lat_cnt = 0, rise_cnt = 0, t;
    logic        clk_prev = 1'b1;
    logic [15:0] e;
    always @(negedge clk) begin
      if (reset) begin
        lat_cnt  = 0;
        rise_cnt = 0;
        clk_prev = 1'b1;
      end else begin
        if (pad_latch) lat_cnt++;
        if (pad_clk && !clk_prev) rise_cnt++;
        clk_prev = pad_clk;
        if (valid) begin
          check($sformatf("h%0d_valid_expected", H), int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = cyc_q.pop_front();
            check($sformatf("h%0d_input0", H), input0, e[15:8]);
            check($sformatf("h%0d_input1", H), input1, e[7:0]);
            check($sformatf("h%0d_valid_cycle", H), cyc, t);
            check($sformatf("h%0d_latch_width", H), lat_cnt, 2*H);
            check($sformatf("h%0d_clk_pulses", H), rise_cnt, 7);
          end
          lat_cnt  = 0;
          rise_cnt = 0;
        end
      end
    end

    task automatic tick();
      @(negedge clk);
    endtask

    task automatic model_reset();
      m_in0 = 8'h00; m_in1 = 8'h00; m_prev0 = 8'h00; m_prev1 = 8'h00;
      exp_q.delete();
      cyc_q.delete();
    endtask

    task automatic model_commit();
`ifdef PAD_DEBOUNCE_EN
      if (btn0 == m_prev0) m_in0 = btn0;
      if (btn1 == m_prev1) m_in1 = btn1;
      m_prev0 = btn0;
      m_prev1 = btn1;
`else
      m_in0 = btn0;
      m_in1 = btn1;
`endif
    endtask

    task automatic issue_start();
      start = 1'b1;
      model_commit();
      exp_q.push_back({m_in0, m_in1});
      cyc_q.push_back(cyc + 2 + 16*H);
      tick();
      start = 1'b0;
    endtask

    task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 16*H + 20) begin
        tick();
        n++;
      end
      check($sformatf("h%0d_poll_completes", H), exp_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
    endtask

    task automatic poll(input logic [7:0] b0, input logic [7:0] b1);
      btn0 = b0;
      btn1 = b1;
      issue_start();
      check($sformatf("h%0d_busy_after_start", H), busy, 1);
      wait_idle();
      tick();
      check($sformatf("h%0d_busy_idle", H), busy, 0);
    endtask

    task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
    endtask

    initial begin
      int c;
      reset = 1'b1;
      repeat (3) tick();
      check($sformatf("h%0d_rst_latch", H), pad_latch, 0);
      check($sformatf("h%0d_rst_pad_clk", H), pad_clk, 1);
      check($sformatf("h%0d_rst_busy", H), busy, 0);
      check($sformatf("h%0d_rst_valid", H), valid, 0);
      check($sformatf("h%0d_rst_input0", H), input0, 0);
      check($sformatf("h%0d_rst_input1", H), input1, 0);
      reset = 1'b0;
      model_reset();
      tick();

      poll(8'h90, 8'h00);
      poll(8'hFF, 8'h01);

      // extra starts while busy and on the DONE cycle must be dropped
      btn0 = 8'h5A;
      btn1 = 8'hA5;
      c = cyc;
      issue_start();
      while (cyc < c + 5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < c + 1 + 16*H) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      poll(8'h5A, 8'hA5);

      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(1, 0) == 0) begin
          btn0 = 8'($urandom);
          btn1 = 8'($urandom);
        end
        poll(btn0, btn1);
      end

      do_reset();
      poll(8'h80, 8'h00);
`ifdef PAD_DEBOUNCE_EN
      check($sformatf("h%0d_deb_first", H), input0, 8'h00);
`endif
      poll(8'h80, 8'h00);
      check($sformatf("h%0d_deb_second", H), input0, 8'h80);
      poll(8'h40, 8'h00);
`ifdef PAD_DEBOUNCE_EN
      check($sformatf("h%0d_deb_hold", H), input0, 8'h80);
`endif
      poll(8'h40, 8'h00);
      check($sformatf("h%0d_deb_fourth", H), input0, 8'h40);

      // abort mid-CLKHI of bit 4
      poll(8'hC3, 8'h3C);
      poll(8'hC3, 8'h3C);
      btn0 = 8'h11;
      btn1 = 8'h22;
      c = cyc;
      issue_start();
      while (cyc < c + 1 + 9*H) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check($sformatf("h%0d_abort_latch", H), pad_latch, 0);
      check($sformatf("h%0d_abort_pad_clk", H), pad_clk, 1);
      check($sformatf("h%0d_abort_busy", H), busy, 0);
      check($sformatf("h%0d_abort_valid", H), valid, 0);
      check($sformatf("h%0d_abort_input0", H), input0, 0);
      check($sformatf("h%0d_abort_input1", H), input1, 0);
      repeat (16*H + 4) tick();
      poll(8'h11, 8'h22);
      poll(8'h11, 8'h22);
      repeat (4) tick();
      done_g = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(gi[0].done_g && gi[1].done_g) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("all_sequences_done", int'(gi[0].done_g && gi[1].done_g), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
